// File: rtl/fifo_unpack.sv
// Drains 32-bit words from an upstream FIFO and serialises them as a
// valid/ready byte stream, flagging the final byte of the word that emptied the FIFO.
module fifo_unpack #(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             CLKP,
  input  logic             RSTNP,
  input  logic             ENP,
  input  logic [31:0]      DOP,
  input  logic             EMPTYP,
  input  logic             LASTP,
  output logic             POPP,
  output logic [7:0]       BYTEP,
  output logic             BVALIDP,
  input  logic             BREADYP,
  output logic             BLASTP,
  output logic [CNT_W-1:0] BCNTP
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

  state_t             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic               last_q, last_d;
  logic               pop_q, pop_d;
  logic [7:0]         byte_q, byte_d;
  logic               bvalid_q, bvalid_d;
  logic               blast_q, blast_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    logic [1:0] pos;
    pos = (MSB_FIRST != 0) ? (2'd3 - i) : i;
    case (pos)
      2'd0:    sel_byte = w[7:0];
      2'd1:    sel_byte = w[15:8];
      2'd2:    sel_byte = w[23:16];
      default: sel_byte = w[31:24];
    endcase
  endfunction

  // BVALIDP is high exactly while in SEND, so the handshake can key off the state.
  assign xfer = (state_q == SEND) && BREADYP;

  always_ff @(posedge CLKP or negedge RSTNP) begin
    if (!RSTNP) begin
      state_q  <= IDLE;
      word_q   <= 32'h0;
      idx_q    <= 2'd0;
      last_q   <= 1'b0;
      pop_q    <= 1'b0;
      byte_q   <= 8'h00;
      bvalid_q <= 1'b0;
      blast_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      pop_q    <= pop_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      blast_q  <= blast_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ENP && !EMPTYP) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = SEND;
      SEND:    if (xfer && (idx_q == 2'd3)) state_d = (ENP && !EMPTYP) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word/index/count bookkeeping; the word is latched as it leaves WAIT.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (state_q == FETCH) last_d = LASTP;
    if (state_q == WAIT) begin
      word_d = DOP;
      idx_d  = 2'd0;
    end
    if (xfer) begin
      idx_d = idx_q + 2'd1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_comb begin
    pop_d    = (state_d == FETCH);
    bvalid_d = (state_d == SEND);
    byte_d   = sel_byte(word_d, idx_d);
    blast_d  = (state_d == SEND) && (idx_d == 2'd3) && last_d;
  end

  assign POPP    = pop_q;
  assign BYTEP   = byte_q;
  assign BVALIDP = bvalid_q;
  assign BLASTP  = blast_q;
  assign BCNTP   = cnt_q;

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: queue-based upstream FIFO, byte-stream scoreboard, directed and random traffic.
module tb_fifo_unpack;

  logic        CLKP = 1'b0;
  logic        RSTNP, ENP, EMPTYP, LASTP, BREADYP;
  logic [31:0] DOP;
  logic        POPP, BVALIDP, BLASTP;
  logic [7:0]  BYTEP;
  logic [15:0] BCNTP;
  logic        POPP1, BVALIDP1, BLASTP1;
  logic [7:0]  BYTEP1;
  logic [3:0]  BCNTP1;

  fifo_unpack #(.MSB_FIRST(1), .CNT_W(16)) u0 (
    .CLKP(CLKP), .RSTNP(RSTNP), .ENP(ENP), .DOP(DOP), .EMPTYP(EMPTYP), .LASTP(LASTP),
    .POPP(POPP), .BYTEP(BYTEP), .BVALIDP(BVALIDP), .BREADYP(BREADYP),
    .BLASTP(BLASTP), .BCNTP(BCNTP));

  fifo_unpack #(.MSB_FIRST(0), .CNT_W(4)) u1 (
    .CLKP(CLKP), .RSTNP(RSTNP), .ENP(ENP), .DOP(DOP), .EMPTYP(EMPTYP), .LASTP(LASTP),
    .POPP(POPP1), .BYTEP(BYTEP1), .BVALIDP(BVALIDP1), .BREADYP(BREADYP),
    .BLASTP(BLASTP1), .BCNTP(BCNTP1));

  always #5 CLKP = ~CLKP;

  typedef struct {
    logic [7:0] bm;
    logic [7:0] bl;
    logic       last;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops = 0;
  int          exp_cnt = 0;
  int          last_pop_cyc = -1;
  bit          tput_en = 1'b0;
  logic [31:0] fifo[$];
  exp_t        expq[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte;
  logic [15:0] prev_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic update_flags();
    EMPTYP = (fifo.size() == 0);
    LASTP  = (fifo.size() == 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    update_flags();
  endtask

  // One clock: check the settled outputs, then advance the upstream FIFO and reference.
  task automatic cycle();
    exp_t        e;
    bit          xfer, pop, bl;
    logic [31:0] w;
    @(negedge CLKP);
    xfer = BVALIDP && BREADYP;
    pop  = POPP && !EMPTYP;
    if (prev_stall) begin
      chk("stall_valid", BVALIDP, 1);
      chk("stall_byte", BYTEP, prev_byte);
      chk("stall_cnt", BCNTP, prev_cnt);
    end
    if (POPP) begin
      chk("pop_when_empty", EMPTYP, 0);
      chk("pop_in_send", BVALIDP, 0);
      chk("u1_pop", POPP1, 1);
    end
    if (!BVALIDP) chk("blast_outside_send", BLASTP, 0);
    if (xfer) begin
      chk("byte_pending", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("byte_msb", BYTEP, e.bm);
        chk("blast", BLASTP, e.last);
        chk("cnt", BCNTP, exp_cnt % 65536);
        chk("u1_valid", BVALIDP1, 1);
        chk("byte_lsb", BYTEP1, e.bl);
        chk("blast_lsb", BLASTP1, e.last);
        chk("cnt_wrap4", BCNTP1, exp_cnt % 16);
        exp_cnt++;
      end
    end
    prev_stall = BVALIDP && !BREADYP;
    prev_byte  = BYTEP;
    prev_cnt   = BCNTP;
    @(posedge CLKP);
    #1;
    cyc++;
    if (pop) begin
      if (tput_en && last_pop_cyc >= 0) chk("pop_interval", cyc - last_pop_cyc, 6);
      last_pop_cyc = cyc;
      pops++;
      bl = (fifo.size() == 1);
      w  = fifo.pop_front();
      DOP = w;
      for (int k = 0; k < 4; k++) begin
        e.bm   = 8'((w >> (8 * (3 - k))) & 32'hFF);
        e.bl   = 8'((w >> (8 * k)) & 32'hFF);
        e.last = bl && (k == 3);
        expq.push_back(e);
      end
    end else begin
      DOP = $urandom();
    end
    update_flags();
  endtask

  task automatic run_until_cnt(input int target, input int maxc);
    int n = 0;
    while (exp_cnt < target && n < maxc) begin
      cycle();
      n++;
    end
    chk("wait_bytes_timeout", exp_cnt >= target, 1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    ENP = 1'b1;
    BREADYP = 1'b1;
    while ((fifo.size() != 0 || expq.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < maxc, 1);
    repeat (3) cycle();
    chk("idle_valid", BVALIDP, 0);
    chk("idle_pop", POPP, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, base;
    RSTNP = 1'b1; ENP = 1'b0; BREADYP = 1'b0; DOP = 32'h0;
    update_flags();
    #2 RSTNP = 1'b0;
    #1;
    chk("rst_pop", POPP, 0);
    chk("rst_valid", BVALIDP, 0);
    chk("rst_byte", BYTEP, 8'h00);
    chk("rst_blast", BLASTP, 0);
    chk("rst_cnt", BCNTP, 0);
    chk("rst_cnt_u1", BCNTP1, 0);
    @(posedge CLKP); @(posedge CLKP); #1;
    RSTNP = 1'b1;
    repeat (2) cycle();

    // Single word drained by itself
    p0 = pops;
    push_word(32'h11000011);
    drain(50);
    chk("single_pops", pops - p0, 1);
    chk("single_cnt", BCNTP, 4);

    // Back-to-back burst at full throughput
    p0 = pops;
    tput_en = 1'b1;
    last_pop_cyc = -1;
    for (int i = 1; i <= 15; i++) push_word(32'h11000011 * i);
    push_word(32'hFFFF7777);
    push_word(32'hFFFFFFFF);
    push_word(32'h00000000);
    drain(300);
    chk("burst_pops", pops - p0, 18);
    tput_en = 1'b0;

    // Backpressure on byte index 1
    base = exp_cnt;
    push_word(32'h66FF0066);
    ENP = 1'b1; BREADYP = 1'b1;
    run_until_cnt(base + 1, 30);
    BREADYP = 1'b0;
    repeat (5) cycle();
    chk("bp_byte", BYTEP, 8'hFF);
    chk("bp_valid", BVALIDP, 1);
    chk("bp_cnt", BCNTP, (base + 1) % 65536);
    drain(50);

    // Enable dropped mid-word with words still queued
    base = exp_cnt;
    push_word($urandom()); push_word($urandom()); push_word($urandom());
    ENP = 1'b1; BREADYP = 1'b1;
    run_until_cnt(base + 1, 30);
    ENP = 1'b0;
    p0 = pops;
    repeat (20) cycle();
    chk("en_no_pop", pops - p0, 0);
    chk("en_word_done", expq.size(), 0);
    chk("en_fifo_left", fifo.size(), 2);
    chk("en_idle_valid", BVALIDP, 0);
    drain(60);

    // Asynchronous reset while byte index 2 is on the output
    base = exp_cnt;
    push_word($urandom()); push_word($urandom());
    ENP = 1'b1; BREADYP = 1'b1;
    run_until_cnt(base + 2, 30);
    #2 RSTNP = 1'b0;
    #1;
    chk("mid_rst_pop", POPP, 0);
    chk("mid_rst_valid", BVALIDP, 0);
    chk("mid_rst_byte", BYTEP, 8'h00);
    chk("mid_rst_blast", BLASTP, 0);
    chk("mid_rst_cnt", BCNTP, 0);
    chk("mid_rst_cnt_u1", BCNTP1, 0);
    expq.delete();
    exp_cnt = 0;
    prev_stall = 1'b0;
    repeat (2) cycle();
    RSTNP = 1'b1;
    p0 = pops;
    drain(60);
    chk("post_rst_pops", pops - p0, 1);
    chk("post_rst_cnt", BCNTP, 4);

    // Random traffic: ready, enable and FIFO refills all randomised
    for (int i = 0; i < 400; i++) begin
      BREADYP = ($urandom_range(0, 9) < 7);
      ENP     = ($urandom_range(0, 9) < 9);
      if (fifo.size() < 6 && $urandom_range(0, 4) == 0) push_word($urandom());
      cycle();
    end
    drain(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
